tri_vertex_feeder: RTL

Upstream stage of the triangle rendering engine. Buffers vertex coordinates arriving from a host on a valid/ready stream, groups them into triangles of three vertices, and replays each triangle into the engine's `nt`/`xi`/`yi` input protocol. A new triangle is launched only when the engine reports not busy. Replaces the hand-driven vertex sequencing used at the engine boundary today.

---
 rtl/tri_vertex_feeder_if.sv | 11 +
 rtl/tri_vertex_feeder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tri_vertex_feeder_if.sv
// Host-to-feeder vertex stream. A vertex transfers on a rising edge where
// vin_valid && vin_ready; the host holds x/y stable while valid waits for ready.
interface tri_vertex_feeder_if;
    logic       vin_valid;
    logic       vin_ready;
    logic [2:0] vin_x;
    logic [2:0] vin_y;

    modport master (output vin_valid, output vin_x, output vin_y, input vin_ready);
    modport slave  (input vin_valid, input vin_x, input vin_y, output vin_ready);
endinterface

// File: rtl/tri_vertex_feeder.sv
// Vertex FIFO plus sequencer that groups vertices into triangles and replays
// them into the engine's nt/xi/yi protocol whenever the engine is idle.
module tri_vertex_feeder #(
    parameter int DEPTH        = 12,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    tri_vertex_feeder_if.slave           vin,
    input  logic                         busy,
    output logic                         nt,
    output logic [2:0]                   xo,
    output logic [2:0]                   yo,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   tri_count,
    output logic [2:0]                   dbg_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND1   = 3'd1,
        SEND2   = 3'd2,
        SEND3   = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            nt_q, nt_d;
    logic [2:0]      xo_q, xo_d;
    logic [2:0]      yo_q, yo_d;
    logic [7:0]      tri_q, tri_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic [5:0]      mem [DEPTH];
    logic [5:0]      rd_data;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign vin.vin_ready = (level_q < LW'(DEPTH));
    assign push          = vin.vin_valid && vin.vin_ready;
    assign rd_data       = mem[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        nt_d    = 1'b0;
        xo_d    = 3'd0;
        yo_d    = 3'd0;
        tri_d   = tri_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q >= LW'(3) && !busy) begin
                    pop          = 1'b1;
                    nt_d         = 1'b1;
                    {xo_d, yo_d} = rd_data;
                    state_d      = SEND1;
                end
            end
            SEND1: begin
                pop          = 1'b1;
                {xo_d, yo_d} = rd_data;
                state_d      = SEND2;
            end
            SEND2: begin
                pop          = 1'b1;
                {xo_d, yo_d} = rd_data;
                state_d      = SEND3;
            end
            SEND3: begin
                tri_d   = tri_q + 8'd1;
                tmo_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // An engine that never raises busy is assumed to have finished already.
                if (busy) begin
                    state_d = WAIT_LO;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(BUSY_TIMEOUT)) state_d = IDLE;
                end
            end
            WAIT_LO: begin
                if (!busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            nt_q     <= 1'b0;
            xo_q     <= 3'd0;
            yo_q     <= 3'd0;
            tri_q    <= 8'd0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            nt_q     <= nt_d;
            xo_q     <= xo_d;
            yo_q     <= yo_d;
            tri_q    <= tri_d;
            tmo_q    <= tmo_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {vin.vin_x, vin.vin_y};
    end

    assign nt        = nt_q;
    assign xo        = xo_q;
    assign yo        = yo_q;
    assign level     = level_q;
    assign tri_count = tri_q;
    assign dbg_state = state_q;
endmodule
